// File: rtl/mpc_pkg.sv
// Shared types and constants for the mpc packet arbiter.
package mpc_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  localparam int MPC_STAT_W = 16;

endpackage

// File: rtl/mpc_rr_pick.sv
// Rotating first-one search: first set request at or above rr_ptr, wrapping to 0.
module mpc_rr_pick #(
  parameter int N     = 16,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  int               j;
  logic [PTR_W-1:0] jj;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      jj = PTR_W'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/mpc_pkt_arb.sv
// Packet-atomic round-robin arbiter of N_PORTS write ports onto one registered output.
// Define MPC_ARB_STATS_EN to add per-port packet counters and an orphan-drop counter.
module mpc_pkt_arb
  import mpc_pkg::*;
#(
  parameter int N_PORTS = 16,
  parameter int DATA_W  = 64,
  parameter int PTR_W   = $clog2(N_PORTS)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [N_PORTS-1:0]        wr_sop,
  input  logic [N_PORTS-1:0]        wr_eop,
  input  logic [N_PORTS-1:0]        wr_vld,
  input  logic [N_PORTS*DATA_W-1:0] wr_data,
  output logic [N_PORTS-1:0]        wr_ready,
  input  logic                      rd_ready,
  output logic                      rd_sop,
  output logic                      rd_eop,
  output logic                      rd_vld,
  output logic [DATA_W-1:0]         rd_data,
  output logic [PTR_W-1:0]          rd_port,
  output logic                      err_drop,
`ifdef MPC_ARB_STATS_EN
  output logic [N_PORTS*MPC_STAT_W-1:0] pkt_cnt,
  output logic [MPC_STAT_W-1:0]         drop_cnt,
`endif
  output logic                      dbg_state,
  output logic [PTR_W-1:0]          dbg_rr_ptr
);

  // Handshake: a beat moves on any cycle where valid and ready are both high;
  // wr_ready is combinational and only ever high together with wr_vld.
  arb_state_e           state;
  logic [PTR_W-1:0]     g;
  logic [PTR_W-1:0]     rr_ptr;
  logic [N_PORTS-1:0]   req;
  logic [N_PORTS-1:0]   win_oh;
  logic [PTR_W-1:0]     win_idx;
  logic                 win_any;
  logic [N_PORTS-1:0]   lock_oh;
  logic [N_PORTS-1:0]   orphan;
  logic                 out_free;
  logic                 xfer;
  logic [PTR_W-1:0]     src;
  logic [DATA_W-1:0]    src_data;
  logic                 src_sop;
  logic                 src_eop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_PORTS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign out_free = !rd_vld || rd_ready;
  assign req      = (state == ARB_IDLE) ? (wr_vld & wr_sop) : '0;

  mpc_rr_pick #(.N(N_PORTS), .PTR_W(PTR_W)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (win_oh),
    .idx    (win_idx),
    .any    (win_any)
  );

  always_comb begin
    lock_oh = '0;
    if (state == ARB_LOCK) lock_oh[g] = 1'b1;
  end

  // Only g can have a packet in flight, so any other non-sop beat is an orphan.
  assign orphan   = wr_vld & ~wr_sop & ~lock_oh;
  assign src      = (state == ARB_LOCK) ? g : win_idx;
  assign xfer     = out_free && ((state == ARB_LOCK) ? wr_vld[g] : win_any);
  assign src_data = wr_data[int'(src)*DATA_W +: DATA_W];
  assign src_sop  = wr_sop[src];
  assign src_eop  = wr_eop[src];

  always_comb begin
    wr_ready = '0;
    if (!rst_in) begin
      wr_ready = orphan;
      if (xfer) wr_ready = wr_ready | ((state == ARB_LOCK) ? lock_oh : win_oh);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= ARB_IDLE;
      g        <= '0;
      rr_ptr   <= '0;
      rd_vld   <= 1'b0;
      rd_sop   <= 1'b0;
      rd_eop   <= 1'b0;
      rd_data  <= '0;
      rd_port  <= '0;
      err_drop <= 1'b0;
    end else begin
      err_drop <= |orphan;
      if (xfer) begin
        rd_vld  <= 1'b1;
        rd_sop  <= src_sop;
        rd_eop  <= src_eop;
        rd_data <= src_data;
        rd_port <= src;
        if (src_eop) begin
          state  <= ARB_IDLE;
          rr_ptr <= ptr_inc(src);
        end else begin
          state <= ARB_LOCK;
          g     <= src;
        end
      end else if (rd_ready) begin
        rd_vld <= 1'b0;
      end
    end
  end

  assign dbg_state  = state;
  assign dbg_rr_ptr = rr_ptr;

`ifdef MPC_ARB_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (xfer && src_eop &&
          pkt_cnt[int'(src)*MPC_STAT_W +: MPC_STAT_W] != {MPC_STAT_W{1'b1}})
        pkt_cnt[int'(src)*MPC_STAT_W +: MPC_STAT_W] <=
          pkt_cnt[int'(src)*MPC_STAT_W +: MPC_STAT_W] + 1'b1;
      if ((|orphan) && drop_cnt != {MPC_STAT_W{1'b1}})
        drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mpc_pkt_arb.sv
// Randomized scoreboard bench for mpc_pkt_arb with a packet-level round-robin model.
module tb_mpc_pkt_arb;
  import mpc_pkg::*;

  localparam int NP = 4;
  localparam int DW = 16;
  localparam int PW = 2;
  localparam int W  = DW + PW + 2;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic [NP-1:0]    wr_sop, wr_eop, wr_vld, wr_ready;
  logic [NP*DW-1:0] wr_data;
  logic             rd_ready, rd_sop, rd_eop, rd_vld, err_drop;
  logic [DW-1:0]    rd_data;
  logic [PW-1:0]    rd_port;
  logic             dbg_state;
  logic [PW-1:0]    dbg_rr_ptr;
`ifdef MPC_ARB_STATS_EN
  logic [NP*16-1:0] pkt_cnt;
  logic [15:0]      drop_cnt;
`endif

  mpc_pkt_arb #(.N_PORTS(NP), .DATA_W(DW)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .wr_sop     (wr_sop),
    .wr_eop     (wr_eop),
    .wr_vld     (wr_vld),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_ready   (rd_ready),
    .rd_sop     (rd_sop),
    .rd_eop     (rd_eop),
    .rd_vld     (rd_vld),
    .rd_data    (rd_data),
    .rd_port    (rd_port),
    .err_drop   (err_drop),
`ifdef MPC_ARB_STATS_EN
    .pkt_cnt    (pkt_cnt),
    .drop_cnt   (drop_cnt),
`endif
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            drv_cyc = 0;
  int            round_start = 0;
  logic [W-1:0]  exp_q[$];
  int            beat_cyc[$];
  int            len[NP];
  int            pos[NP];
  logic [DW-1:0] dat[NP][4];
  int            rr_m = 0;
  int            pkt_m[NP];
  int            drop_m = 0;
  logic          orph_cyc = 1'b0;

  // clock / reset
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in   = 1'b1;
    orph_cyc = 1'b0;
    wr_vld   = '0;
    wr_sop   = '0;
    wr_eop   = '0;
    rd_ready = 1'b1;
    repeat (2) @(negedge clk_in);
    exp_q.delete();
    rr_m   = 0;
    drop_m = 0;
    for (int i = 0; i < NP; i++) begin
      pkt_m[i] = 0;
      len[i]   = 0;
      pos[i]   = 0;
    end
    rst_in = 1'b0;
  endtask

  // driver: one cycle of inputs, then advance each port on its own handshake
  task automatic drive_cycle(input logic rdy, input logic [NP-1:0] orph);
    logic [NP-1:0] is_orph;
    logic          stall;
    @(negedge clk_in);
    drv_cyc  = cyc;
    rd_ready = rdy;
    is_orph  = '0;
    for (int i = 0; i < NP; i++) begin
      if (pos[i] < len[i]) begin
        wr_vld[i] = 1'b1;
        wr_sop[i] = (pos[i] == 0);
        wr_eop[i] = (pos[i] == len[i] - 1);
        wr_data[i*DW +: DW] = dat[i][pos[i]];
      end else if (orph[i]) begin
        wr_vld[i]  = 1'b1;
        wr_sop[i]  = 1'b0;
        wr_eop[i]  = 1'($urandom_range(0, 1));
        wr_data[i*DW +: DW] = DW'($urandom);
        is_orph[i] = 1'b1;
      end else begin
        wr_vld[i] = 1'b0;
        wr_sop[i] = 1'b0;
        wr_eop[i] = 1'b0;
      end
    end
    #2;
    stall = rd_vld && !rd_ready;
    for (int i = 0; i < NP; i++) begin
      if (is_orph[i]) check("orphan_ready", 32'(wr_ready[i]), 32'd1);
      else if (stall) check("stall_ready", 32'(wr_ready[i]), 32'd0);
      if (wr_ready[i] && !is_orph[i] && pos[i] < len[i]) pos[i]++;
    end
    orph_cyc = |is_orph;
    if (|is_orph) drop_m++;
  endtask

  // reference model: every port of the round waits with sop, so grants follow
  // rotated port order starting at the round-robin pointer
  task automatic load_round();
    int p;
    int last;
    last = -1;
    for (int k = 0; k < NP; k++) begin
      p = (rr_m + k) % NP;
      if (len[p] > 0) begin
        for (int b = 0; b < len[p]; b++)
          exp_q.push_back({(b == 0), (b == len[p] - 1), PW'(p), dat[p][b]});
        pkt_m[p]++;
        last = p;
      end
    end
    if (last >= 0) rr_m = (last + 1) % NP;
    for (int i = 0; i < NP; i++) pos[i] = 0;
  endtask

  task automatic run_round(input int rdy_pct, input int orph_pct, input int stall_from,
                           input int stall_len, input int fo_port, input int fo_cyc);
    int            n;
    logic          done;
    logic          rdy;
    logic [NP-1:0] orph;
    load_round();
    n    = 0;
    done = 1'b0;
    while (!done) begin
      rdy = ($urandom_range(1, 100) <= rdy_pct);
      if (n >= stall_from && n < stall_from + stall_len) rdy = 1'b0;
      orph = '0;
      for (int i = 0; i < NP; i++)
        if (pos[i] >= len[i] && $urandom_range(1, 100) <= orph_pct) orph[i] = 1'b1;
      if (fo_cyc >= 0 && n == fo_cyc) orph[fo_port] = 1'b1;
      drive_cycle(rdy, orph);
      if (n == 0) round_start = drv_cyc;
      n++;
      done = (exp_q.size() == 0);
      for (int i = 0; i < NP; i++) if (pos[i] < len[i]) done = 1'b0;
      if (!done && n > 400) begin
        total++;
        bad++;
        $display("FAIL round_timeout: got %0d beats pending expected 0", exp_q.size());
        exp_q.delete();
        done = 1'b1;
      end
    end
    for (int i = 0; i < NP; i++) len[i] = 0;
    drive_cycle(1'b1, '0);
    check("rr_ptr", 32'(dbg_rr_ptr), 32'(rr_m));
    check("state_idle", 32'(dbg_state), 32'(ARB_IDLE));
`ifdef MPC_ARB_STATS_EN
    for (int i = 0; i < NP; i++) check("pkt_cnt", 32'(pkt_cnt[i*16 +: 16]), 32'(pkt_m[i]));
    check("drop_cnt", 32'(drop_cnt), 32'(drop_m));
`endif
  endtask

  task automatic fill(input int p, input int l);
    len[p] = l;
    for (int b = 0; b < 4; b++) dat[p][b] = DW'($urandom);
  endtask

  // scoreboard monitor
  initial begin : monitor
    logic         prev_orph;
    logic         prev_stall;
    logic [W-1:0] held;
    logic [W-1:0] got;
    logic [W-1:0] e;
    prev_orph  = 1'b0;
    prev_stall = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk_in);
      #3;
      if (rst_in) begin
        prev_orph  = 1'b0;
        prev_stall = 1'b0;
      end else begin
        check("err_drop", 32'(err_drop), 32'(prev_orph));
        prev_orph = orph_cyc;
        got = {rd_sop, rd_eop, rd_port, rd_data};
        if (prev_stall) check("stall_hold", 32'({rd_vld, got}), 32'({1'b1, held}));
        if (rd_vld && rd_ready) begin
          beat_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got %0h expected none", got);
          end else begin
            e = exp_q.pop_front();
            check("beat", 32'(got), 32'(e));
          end
        end
        prev_stall = rd_vld && !rd_ready;
        held       = got;
      end
    end
  end

  initial begin : stim
    logic [NP-1:0] mask;
    for (int i = 0; i < NP; i++) begin
      len[i]   = 0;
      pos[i]   = 0;
      pkt_m[i] = 0;
    end
    rst_in   = 1'b1;
    wr_vld   = '1;
    wr_sop   = '1;
    wr_eop   = '0;
    wr_data  = '1;
    rd_ready = 1'b1;
    repeat (2) @(negedge clk_in);
    #1;
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_rd_vld", 32'(rd_vld), 32'd0);
    check("rst_rd_flags", 32'({rd_sop, rd_eop, err_drop}), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_port", 32'(rd_port), 32'd0);
    check("rst_rr_ptr", 32'(dbg_rr_ptr), 32'd0);
    do_reset();

    // single port, 3 beats, continuous rd_ready: beats on t+1..t+3
    fill(2, 3);
    beat_cyc.delete();
    run_round(100, 0, -1, 0, 0, -1);
    check("lat_count", 32'(beat_cyc.size()), 32'd3);
    for (int b = 0; b < 3; b++)
      if (b < beat_cyc.size()) check("lat_cycle", 32'(beat_cyc[b]), 32'(round_start + 1 + b));

    // contention from rr_ptr=0: ports 0,1,3 two beats each
    do_reset();
    fill(0, 2);
    fill(1, 2);
    fill(3, 2);
    run_round(100, 0, -1, 0, 0, -1);

    // backpressure: rd_ready low for 3 cycles mid-packet
    fill(2, 4);
    run_round(100, 0, 2, 3, 0, -1);

    // orphan on port 1 while port 0 holds the lock
    fill(0, 4);
    run_round(100, 0, -1, 0, 1, 2);

    // single-beat packet, then reset in the middle of a 4-beat packet
    do_reset();
    fill(3, 1);
    run_round(100, 0, -1, 0, 0, -1);
`ifdef MPC_ARB_STATS_EN
    check("pkt_cnt3_pre", 32'(pkt_cnt[3*16 +: 16]), 32'd1);
`endif
    fill(0, 4);
    load_round();
    drive_cycle(1'b1, '0);
    drive_cycle(1'b1, '0);
    len[0] = 0;
    drive_cycle(1'b1, '0);
    do_reset();
    #3;
    check("post_rst_vld", 32'(rd_vld), 32'd0);
    check("post_rst_rr", 32'(dbg_rr_ptr), 32'd0);
    check("post_rst_state", 32'(dbg_state), 32'(ARB_IDLE));
`ifdef MPC_ARB_STATS_EN
    check("pkt_cnt3_post", 32'(pkt_cnt[3*16 +: 16]), 32'd0);
`endif
    // a leftover continuation beat after reset must be dropped, not forwarded
    drive_cycle(1'b1, 4'b0001);
    fill(0, 4);
    run_round(100, 0, -1, 0, 0, -1);

    // randomized rounds with backpressure and orphans
    for (int r = 0; r < 40; r++) begin
      mask = NP'($urandom_range(1, (1 << NP) - 1));
      for (int i = 0; i < NP; i++)
        if (mask[i]) fill(i, $urandom_range(1, 4));
      run_round(70, 10, -1, 0, 0, -1);
    end

    repeat (3) drive_cycle(1'b1, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
